// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected dot-product engine.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fc_dp_state_t;

    localparam int FC_WORD_SIZE   = 16;
    localparam int FC_FRAC_BITS   = 8;
    localparam int FC_BUFFER_SIZE = 120;

    // Smallest accumulator that cannot wrap: full product plus growth for every term.
    function automatic int fc_acc_width(input int word_size, input int buffer_size);
        return 2 * word_size + $clog2(buffer_size);
    endfunction

endpackage

// File: rtl/fc_round_sat.sv
// Rounds (half toward +inf), rescales, saturates and optionally rectifies an accumulator.
// Latency: combinational.
// Backpressure: none. ReLU stage is present only with FC_DOT_PRODUCT_RELU_EN defined.
module fc_round_sat
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int WORD_SIZE = FC_WORD_SIZE,
    parameter int FRAC_BITS = FC_FRAC_BITS
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [WORD_SIZE-1:0] result
);

    // One guard bit so adding the half-LSB can never overflow.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF  = RW'(1) << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAX_V = {{(RW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;
    logic [WORD_SIZE-1:0] sat;

    // Round, arithmetic shift, clamp to word range, then optional ReLU.
    always_comb begin
        biased  = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
        shifted = biased >>> FRAC_BITS;
        if (shifted > MAX_V) begin
            sat = MAX_V[WORD_SIZE-1:0];
        end else if (shifted < MIN_V) begin
            sat = MIN_V[WORD_SIZE-1:0];
        end else begin
            sat = shifted[WORD_SIZE-1:0];
        end
`ifdef FC_DOT_PRODUCT_RELU_EN
        result = sat[WORD_SIZE-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/fc_dot_product.sv
// Sequential neuron: o_result = sat(round(bias + sum input[i]*weight[i])), one MAC per clock.
// Latency: n+1 cycles from accepted start to o_valid pulse (n = min(i_count, BUFFER_SIZE)).
// Backpressure: none; i_start ignored while o_busy, operand buffers must hold while o_busy.
// Optional ReLU on the output is enabled by defining FC_DOT_PRODUCT_RELU_EN.
module fc_dot_product
    import fc_pkg::*;
#(
    parameter int BUFFER_SIZE = FC_BUFFER_SIZE,
    parameter int WORD_SIZE   = FC_WORD_SIZE,
    parameter int FRAC_BITS   = FC_FRAC_BITS,
    parameter int ACC_WIDTH   = 40,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic [COUNT_WIDTH-1:0]                i_count,
    input  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] i_inputs,
    input  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] i_weights,
    input  logic [WORD_SIZE-1:0]                  i_bias,
    output logic                                  o_busy,
    output logic [WORD_SIZE-1:0]                  o_result,
    output logic                                  o_valid
);

    // An undersized ACC_WIDTH is widened so the accumulator can never wrap.
    localparam int ACC_MIN = fc_acc_width(WORD_SIZE, BUFFER_SIZE);
    localparam int ACC_W   = (ACC_WIDTH > ACC_MIN) ? ACC_WIDTH : ACC_MIN;
    localparam int IDX_W   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [COUNT_WIDTH-1:0] BUF_N = COUNT_WIDTH'(BUFFER_SIZE);

    fc_dp_state_t                state;
    logic signed [ACC_W-1:0]     acc;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            last;
    logic [COUNT_WIDTH-1:0]      n_clamp;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic [ACC_W-1:0]            prod_ext;
    logic [ACC_W-1:0]            bias_ext;
    logic [WORD_SIZE-1:0]        rounded;

    assign n_clamp  = (i_count > BUF_N) ? BUF_N : i_count;
    assign prod     = $signed(i_inputs[idx]) * $signed(i_weights[idx]);
    assign prod_ext = {{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
    assign bias_ext = {{(ACC_W-WORD_SIZE){i_bias[WORD_SIZE-1]}}, i_bias} << FRAC_BITS;
    assign o_busy   = (state != IDLE);

    fc_round_sat #(
        .ACC_WIDTH (ACC_W),
        .WORD_SIZE (WORD_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc    (acc),
        .result (rounded)
    );

    // Control FSM, index counter, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            idx      <= '0;
            last     <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        acc   <= bias_ext;
                        idx   <= '0;
                        last  <= IDX_W'(n_clamp - 1'b1);
                        state <= (n_clamp != '0) ? MAC : ROUND;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (idx == last) begin
                        state <= ROUND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ROUND: begin
                    o_result <= rounded;
                    o_valid  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_dot_product.sv
// Directed bench for fc_dot_product: Q8.8 vectors with hand-computed results and latencies.
// Latency: n/a.
// Backpressure: n/a.
module tb_fc_dot_product;
    import fc_pkg::*;

    localparam int BS = 120;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_start = 1'b0;
    logic [9:0]            i_count = '0;
    logic [BS-1:0][15:0]   i_inputs;
    logic [BS-1:0][15:0]   i_weights;
    logic [15:0]           i_bias = '0;
    logic                  o_busy;
    logic [15:0]           o_result;
    logic                  o_valid;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef FC_DOT_PRODUCT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    fc_dot_product dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_count   (i_count),
        .i_inputs  (i_inputs),
        .i_weights (i_weights),
        .i_bias    (i_bias),
        .o_busy    (o_busy),
        .o_result  (o_result),
        .o_valid   (o_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] relu(input logic [15:0] v);
        return (RELU && v[15]) ? 16'h0000 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Background pattern in every slot so reads past the programmed count corrupt the result.
    task automatic fill(input logic [15:0] a, input logic [15:0] w);
        for (int k = 0; k < BS; k++) begin
            i_inputs[k]  = a;
            i_weights[k] = w;
        end
    endtask

    // Start one job, optionally re-pulse i_start at cycle 'poke', check latency/result/pulse width.
    task automatic run(input string tag, input int cnt, input logic [15:0] bias,
                       input int exp_lat, input logic [15:0] exp_res, input int poke);
        int lat;
        bit seen;
        @(negedge clk);
        i_start = 1'b1;
        i_count = 10'(cnt);
        i_bias  = bias;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke) begin
                i_start = 1'b1;
                i_count = 10'd1;
            end else begin
                i_start = 1'b0;
            end
            if (o_valid) seen = 1'b1;
        end
        i_start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(o_result), 32'(exp_res));
        chk({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, 32'(o_valid), 32'd0);
        chk({tag, "_hold"}, 32'(o_result), 32'(exp_res));
    endtask

    initial begin
        int vcount;
        fill(16'h1234, 16'h4321);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 32'(o_result), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic MAC: 1*0.5 + 2*0.5 + 3*0.5 = 3.0
        fill(16'h1234, 16'h4321);
        i_inputs[0] = 16'h0100; i_inputs[1] = 16'h0200; i_inputs[2] = 16'h0300;
        i_weights[0] = 16'h0080; i_weights[1] = 16'h0080; i_weights[2] = 16'h0080;
        run("basic", 3, 16'h0000, 4, 16'h0300, 0);

        // Zero count returns the bias
        run("zero_cnt", 0, 16'h0180, 1, 16'h0180, 0);

        // Mixed signs: 2*1.5 + (-1)*1 - 0.5 = 1.5
        fill(16'h1234, 16'h4321);
        i_inputs[0] = 16'h0200; i_inputs[1] = 16'hFF00;
        i_weights[0] = 16'h0180; i_weights[1] = 16'h0100;
        run("mixed", 2, 16'hFF80, 3, relu(16'h0180), 0);

        // Positive saturation
        fill(16'h7FFF, 16'h7FFF);
        run("sat_pos", 2, 16'h7FFF, 3, 16'h7FFF, 0);

        // Negative saturation (rectified to zero with ReLU)
        fill(16'h7FFF, 16'h8000);
        run("sat_neg", 2, 16'h0000, 3, relu(16'h8000), 0);

        // Rounding: exact half LSB rounds up, just below half rounds down
        fill(16'h1234, 16'h4321);
        i_inputs[0] = 16'h0001; i_weights[0] = 16'h0080;
        run("round_half", 1, 16'h0000, 2, 16'h0001, 0);
        i_weights[0] = 16'h007F;
        run("round_below", 1, 16'h0000, 2, 16'h0000, 0);
        // Negative half rounds toward +inf to zero; just past half gives -1 LSB
        i_inputs[0] = 16'hFFFF; i_weights[0] = 16'h0080;
        run("round_neg_half", 1, 16'h0000, 2, 16'h0000, 0);
        i_weights[0] = 16'h0081;
        run("round_neg", 1, 16'h0000, 2, relu(16'hFFFF), 0);

        // Count clamp to 120 terms, plus an ignored start pulse mid-run
        fill(16'h0001, 16'h0100);
        run("clamp", 200, 16'h0000, 121, 16'h0078, 50);

        // Back-to-back: second start accepted in the cycle o_valid is high
        @(negedge clk);
        i_start = 1'b1; i_count = 10'd0; i_bias = 16'h0040;
        @(posedge clk); #1;
        i_bias = 16'h0050;
        @(posedge clk); #1;
        chk("b2b_valid1", 32'(o_valid), 32'd1);
        chk("b2b_result1", 32'(o_result), 32'h0040);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("b2b_busy2", 32'(o_busy), 32'd1);
        chk("b2b_gap", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        chk("b2b_valid2", 32'(o_valid), 32'd1);
        chk("b2b_result2", 32'(o_result), 32'h0050);

        // Reset on the 3rd MAC edge aborts the run; rst wins over a concurrent start
        fill(16'h0100, 16'h0100);
        @(negedge clk);
        i_start = 1'b1; i_count = 10'd10; i_bias = 16'h0000;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_prio_busy", 32'(o_busy), 32'd0);
        rst = 1'b0; i_start = 1'b0;
        vcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (o_valid) vcount++;
        end
        chk("rst_no_valid", 32'(vcount), 32'd0);
        i_inputs[0] = 16'h0300; i_weights[0] = 16'h0200;
        run("post_rst", 1, 16'h0000, 2, 16'h0600, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_dot_product.md
# fc_dot_product

Sequential dot-product engine that directly consumes the DMA buffer. It computes one fully-connected neuron output as bias + Σ input[i]·weight[i] over a programmable count, performing one signed fixed-point multiply-accumulate per clock. The result is rounded and saturated back to word width, then presented with a one-cycle valid pulse to the layer controller.

## Interface
- BUFFER_SIZE, 120: number of entries in each operand vector.
- WORD_SIZE, 16: operand and result width, signed two's complement.
- FRAC_BITS, 8: fractional bits of the Q format; must satisfy 1 ≤ FRAC_BITS < WORD_SIZE.
- ACC_WIDTH, 40: accumulator width; must be ≥ 2·WORD_SIZE + ceil(log2(BUFFER_SIZE)).
- COUNT_WIDTH, 10: width of i_count.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_count  in  COUNT_WIDTH  number of terms, latched on an accepted start.
- i_inputs  in  [BUFFER_SIZE][WORD_SIZE]  activation vector from the input DMA buffer.
- i_weights  in  [BUFFER_SIZE][WORD_SIZE]  weight vector from the weight DMA buffer.
- i_bias  in  WORD_SIZE  neuron bias, latched on an accepted start.
- o_busy  out  1  high whenever the state is not IDLE.
- o_result  out  WORD_SIZE  last completed neuron output; holds until the next completion.
- o_valid  out  1  one-cycle pulse when o_result updates.

## Operation
- FSM states are IDLE, MAC and ROUND.
- **IDLE:**
  - On i_start, latch n = min(i_count, BUFFER_SIZE).
  - Load acc with sign_extend(i_bias) << FRAC_BITS.
  - Clear idx to 0.
  - Go to MAC if n > 0, otherwise go to ROUND.
- **MAC:**
  - Each cycle: acc += sext(i_inputs[idx]) * sext(i_weights[idx]), using a full 2·WORD_SIZE-bit signed product; then idx++.
  - After the term with idx == n-1, go to ROUND.
- **ROUND:**
  - Compute r = (acc + (1 << (FRAC_BITS-1))) >>> FRAC_BITS, an arithmetic shift that rounds half toward +∞.
  - Saturate r to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - Register the saturated value into o_result, pulse o_valid, and return to IDLE.
- The accumulator never wraps. With the ACC_WIDTH rule satisfied, overflow is impossible.
- i_inputs and i_weights are not latched. The upstream DMA buffers must stay stable while o_busy is high.
- i_start while busy is ignored and is not queued.
- n == 0 is not an error: the result equals i_bias.
- i_count > BUFFER_SIZE is clamped silently.

## Timing
- Reset values: o_result = 0, o_valid = 0, o_busy = 0, state = IDLE, acc = 0, idx = 0.
- Start accepted at edge E0: o_busy rises after E0.
- MAC terms are performed at edges E1 through En.
- At edge E(n+1): o_result updates, o_valid is high for exactly one cycle, and o_busy falls.
- Latency from the start edge to o_valid is n+1 cycles (1 cycle for n = 0).
- Back-to-back operation: i_start is accepted in the same cycle o_valid is high, because the state is already IDLE.
- rst asserted in any state at any edge:
  - Returns to IDLE and applies all reset values.
  - Any in-flight result is discarded, and no o_valid is produced for it.
- rst has priority over i_start on the same edge.

## Configuration
- Macro: FC_DOT_PRODUCT_RELU_EN.
- Defined: ROUND applies ReLU after saturation, so negative results become 0 and o_result is never negative.
- Undefined: the saturated signed result passes through unchanged.
- Latency is identical in both builds.

## Structure
- Package fc_pkg holds:
  - the state enum fc_dp_state_t {IDLE, MAC, ROUND};
  - the default constants FC_WORD_SIZE = 16, FC_FRAC_BITS = 8, FC_BUFFER_SIZE = 120;
  - the FC_ACC_WIDTH derivation function.
- Sub-module fc_round_sat (combinational) performs the round, shift, saturate and optional ReLU steps, parameterized by ACC_WIDTH, WORD_SIZE and FRAC_BITS.
- Top-level fc_dot_product contains the FSM, the idx counter, the accumulator and the output registers.

## Test plan
All values below are Q8.8.
- **Basic MAC:** count = 3, inputs {0x0100, 0x0200, 0x0300}, weights 0x0080 each, bias 0 -> o_result = 0x0300, o_valid in the 4th cycle after start, o_busy high for 4 cycles.
- **Zero count:** count = 0, bias 0x0180 -> o_result = 0x0180, o_valid 1 cycle after start.
- **Saturation:**
  - count = 2, all operands 0x7FFF -> o_result = 0x7FFF.
  - inputs 0x7FFF, weights 0x8000 -> 0x8000 without the macro, 0x0000 with FC_DOT_PRODUCT_RELU_EN.
- **Rounding:**
  - count = 1, input 0x0001, weight 0x0080 (product 0x80, a half LSB) -> 0x0001.
  - weight 0x007F -> 0x0000.
- **Clamp and ignore:**
  - count = 200 with all inputs 0x0001 and weights 0x0100 -> o_result = 0x0078 (120 terms), latency 121 cycles.
  - A second i_start pulse mid-run is ignored.
- **Reset mid-operation:**
  - count = 10, rst high at the 3rd MAC cycle -> o_busy = 0, o_result = 0, and no o_valid pulse for the aborted run.
  - A following start with count = 1 completes normally.
